// File: rtl/arm_pkg.sv
// arm_pkg: definitions shared by the data-memory path.
//   - ctrlState_t : SRAM controller FSM states
//   - DEF_BASE_ADDR, DEF_WAIT_CYCLES : parameter defaults
//   - SRAM_DQ_W, SRAM_ADDR_W : external SRAM geometry
//   - wordIndex() : byte address to data-memory word index
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } ctrlState_t;

  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int SRAM_DQ_W       = 16;
  localparam int SRAM_ADDR_W     = 18;

  // Word index relative to the start of the data-memory window.
  function automatic logic [31:0] wordIndex(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit MEM-stage load/store into two 16-bit
// accesses on an external asynchronous SRAM, each lasting WAIT_CYCLES cycles.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   rdEn, wrEn      load / store request (store wins if both)
//   address         byte address; writeData store data
//   readData        load result, valid in DONE
//   ready           0 while a request is pending or in progress
//   sramDq          bidirectional SRAM data bus
//   sramAddr        SRAM half-word address
//   sramWeN/sramOeN SRAM write / output enables, active low
module sram_controller
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdEn,
  input  logic                 wrEn,
  input  logic [31:0]          address,
  input  logic [31:0]          writeData,
  output logic [31:0]          readData,
  output logic                 ready,
  inout  wire  [SRAM_DQ_W-1:0] sramDq,
  output logic [ADDR_W-1:0]    sramAddr,
  output logic                 sramWeN,
  output logic                 sramOeN
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  ctrlState_t            state, nextState;
  logic [CNT_W-1:0]      waitCnt, nextCnt;
  logic [ADDR_W-2:0]     latchWi, nextWi;
  logic [31:0]           latchData, nextData;
  logic                  latchWrite, nextWrite;
  logic                  sampleLo, sampleHi;
  logic [31:0]           wiFull;

  // Bus controls are computed for the coming cycle and registered so the
  // SRAM pins never see decode glitches.
  logic                  busNext;
  logic                  nextWeN, nextOeN, nextDqOe;
  logic [ADDR_W-1:0]     nextAddr;
  logic [SRAM_DQ_W-1:0]  nextDqOut;
  logic                  dqOe;
  logic [SRAM_DQ_W-1:0]  dqOut;

  assign wiFull = wordIndex(address, 32'(BASE_ADDR));
  assign sramDq = dqOe ? dqOut : {SRAM_DQ_W{1'bz}};

  // Next-state, latch and bus-control decode.
  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    nextWi    = latchWi;
    nextData  = latchData;
    nextWrite = latchWrite;
    sampleLo  = 1'b0;
    sampleHi  = 1'b0;
    case (state)
      IDLE: begin
        if (wrEn || rdEn) begin
          nextState = LO;
          nextCnt   = '0;
          nextWi    = wiFull[ADDR_W-2:0];
          nextData  = writeData;
          nextWrite = wrEn;
        end else begin
          nextCnt = '0;
        end
      end
      LO: begin
        if (waitCnt == LAST_CNT) begin
          nextState = HI;
          nextCnt   = '0;
          sampleLo  = ~latchWrite;
        end else begin
          nextCnt = waitCnt + CNT_W'(1);
        end
      end
      HI: begin
        if (waitCnt == LAST_CNT) begin
          nextState = DONE;
          nextCnt   = '0;
          sampleHi  = ~latchWrite;
        end else begin
          nextCnt = waitCnt + CNT_W'(1);
        end
      end
      DONE: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase

    busNext   = (nextState == LO) || (nextState == HI);
    // WE_N releases on the last cycle of each half for address/data hold.
    nextWeN   = ~(busNext && nextWrite && (nextCnt != LAST_CNT));
    nextOeN   = ~(busNext && !nextWrite);
    nextDqOe  = busNext && nextWrite;
    nextAddr  = busNext ? {nextWi, (nextState == HI)} : {ADDR_W{1'b0}};
    nextDqOut = (nextState == HI) ? nextData[31:16] : nextData[15:0];
  end

  // Stall the pipeline from the cycle a request first appears until DONE.
  always_comb begin
    case (state)
      IDLE:    ready = ~(rdEn | wrEn);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // State, latched request, bus pins and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      latchWi    <= '0;
      latchData  <= 32'h0000_0000;
      latchWrite <= 1'b0;
      readData   <= 32'h0000_0000;
      sramWeN    <= 1'b1;
      sramOeN    <= 1'b1;
      sramAddr   <= {ADDR_W{1'b0}};
      dqOe       <= 1'b0;
      dqOut      <= {SRAM_DQ_W{1'b0}};
    end else begin
      state      <= nextState;
      waitCnt    <= nextCnt;
      latchWi    <= nextWi;
      latchData  <= nextData;
      latchWrite <= nextWrite;
      sramWeN    <= nextWeN;
      sramOeN    <= nextOeN;
      sramAddr   <= nextAddr;
      dqOe       <= nextDqOe;
      dqOut      <= nextDqOut;
      if (sampleLo) begin
        readData[15:0] <= sramDq;
      end
      if (sampleHi) begin
        readData[31:16] <= sramDq;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Behavioural asynchronous SRAM: writes on the rising edge of WE_N using the
// address/data held while WE_N was low; drives the bus while OE_N is low.
module sram_model #(
  parameter int AW = 18
) (
  input  logic          weN,
  input  logic          oeN,
  input  logic [AW-1:0] addr,
  inout  wire  [15:0]   dq
);
  logic [15:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;

  always_latch begin
    if (!weN) begin
      wAddr <= addr;
      wData <= dq;
    end
  end

  always @(posedge weN) begin
    mem[wAddr] <= wData;
  end

  assign dq = (!oeN) ? mem[addr] : 16'hzzzz;
endmodule

module tb_sram_controller;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdEn, wrEn;
  logic [31:0] address, writeData, readData;
  logic        ready, sramWeN, sramOeN;
  logic [17:0] sramAddr;
  wire  [15:0] sramDq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .ADDR_W(18), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .sramDq(sramDq), .sramAddr(sramAddr), .sramWeN(sramWeN), .sramOeN(sramOeN)
  );

  sram_model #(.AW(18)) u_mem (.weN(sramWeN), .oeN(sramOeN), .addr(sramAddr), .dq(sramDq));

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access starting at the next falling edge (cycle 0).
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] expRd);
    logic [17:0] expLo;
    logic [31:0] wi;
    wi    = (addr - 32'd1024) >> 2;
    expLo = {wi[16:0], 1'b0};
    @(negedge clk);
    wrEn = wr; rdEn = rd; address = addr; writeData = data;
    #1;
    check("ready_c0", {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 2*W+1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Drop the request: the access must complete on latched values.
        wrEn = 1'b0; rdEn = 1'b0; address = 32'h0; writeData = 32'h0;
        #1;
        check("addr_lo", {14'd0, sramAddr}, {14'd0, expLo});
        check("wen_lo_first", {31'd0, sramWeN}, {31'd0, ~wr});
        check("oen_lo_first", {31'd0, sramOeN}, {31'd0, wr});
      end
      if (k == W) check("wen_lo_hold", {31'd0, sramWeN}, 32'd1);
      if (k == W+1) check("addr_hi", {14'd0, sramAddr}, {14'd0, expLo | 18'd1});
      if (k <= 2*W) check("ready_busy", {31'd0, ready}, 32'd0);
      if (k == 2*W+1) begin
        check("ready_done", {31'd0, ready}, 32'd1);
        check("readData_done", readData, expRd);
        check("oen_done", {31'd0, sramOeN}, 32'd1);
        check("addr_done", {14'd0, sramAddr}, 32'd0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'h11112222, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 32'h11112222};
    vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h11112222};
    vecs[5] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'h0000FFFF, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b1, 32'd1040, 32'h00000000, 32'h0000FFFF};

    rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0; address = 32'h0; writeData = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_wen", {31'd0, sramWeN}, 32'd1);
    check("rst_oen", {31'd0, sramOeN}, 32'd1);
    check("rst_addr", {14'd0, sramAddr}, 32'd0);
    check("rst_readData", readData, 32'd0);
    tests++;
    if (sramDq !== 16'hzzzz) begin
      fails++;
      $display("FAIL rst_dq: got %h expected zzzz", sramDq);
    end
    rst = 1'b1;

    // Back-to-back accesses: each starts the cycle after the previous DONE.
    for (int i = 0; i < 8; i++) begin
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].expRd);
    end

    check("mem0", {16'd0, u_mem.mem[0]}, 32'h0000BEEF);
    check("mem1", {16'd0, u_mem.mem[1]}, 32'h0000DEAD);
    check("mem2", {16'd0, u_mem.mem[2]}, 32'h00002222);
    check("mem3", {16'd0, u_mem.mem[3]}, 32'h00001111);
    check("mem4", {16'd0, u_mem.mem[4]}, 32'h0000A5A5);
    check("mem5", {16'd0, u_mem.mem[5]}, 32'h0000A5A5);

    // Reset pulled low during cycle 3 of a write to 1036.
    @(negedge clk);
    wrEn = 1'b1; address = 32'd1036; writeData = 32'h13579BDF;
    @(negedge clk);
    wrEn = 1'b0; address = 32'h0; writeData = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_wen", {31'd0, sramWeN}, 32'd1);
    check("midrst_oen", {31'd0, sramOeN}, 32'd1);
    check("midrst_addr", {14'd0, sramAddr}, 32'd0);
    check("midrst_readData", readData, 32'd0);
    rst = 1'b1;

    access(1'b1, 1'b0, 32'd1036, 32'h2468ACE0, 32'h00000000);
    access(1'b0, 1'b1, 32'd1036, 32'h00000000, 32'h2468ACE0);
    check("mem6", {16'd0, u_mem.mem[6]}, 32'h0000ACE0);
    check("mem7", {16'd0, u_mem.mem[7]}, 32'h00002468);

    // Idle with no request: zero-latency ready.
    @(negedge clk);
    #1;
    check("idle_ready", {31'd0, ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
